// File: rtl/sample_sequencer_if.sv
// Sample sequencer bus: ADC handshake plus sample bank write port.
// master drives the ADC request and bank writes, slave answers the ADC.
interface sample_sequencer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 14,
  parameter int IDX_W      = 4
);
  logic                  adc_start;
  logic                  adc_done;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [N-1:0]          enables;
  logic [DATA_WIDTH-1:0] in_smpl;
  logic [IDX_W-1:0]      wr_idx;
  logic                  frame_done;

  modport master (
    output adc_start,
    output enables,
    output in_smpl,
    output wr_idx,
    output frame_done,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    input  enables,
    input  in_smpl,
    input  wr_idx,
    input  frame_done,
    output adc_done,
    output adc_data
  );
endinterface

// File: rtl/sample_sequencer.sv
// Periodic ADC capture controller: paces conversions, writes each
// result into an N-slot bank and flags the end of every frame.
module sample_sequencer #(
  parameter int DATA_WIDTH  = 12,
  parameter int N           = 14,
  parameter int IDX_W       = 4,
  parameter int PERIOD_W    = 16,
  parameter int ADC_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [PERIOD_W-1:0] period,
  output logic                busy,
  output logic                timeout_err,
  sample_sequencer_if.master  bus
);

  localparam int TO_W = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ADC_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE     = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CONV,
    WRITE
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [TO_W-1:0]     to_cnt;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      to_cnt         <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      bus.adc_start  <= 1'b0;
      bus.enables    <= '0;
      bus.in_smpl    <= '0;
      bus.wr_idx     <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.adc_start  <= 1'b0;
      bus.enables    <= '0;
      bus.frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state       <= WAIT;
            busy        <= 1'b1;
            bus.wr_idx  <= '0;
            tick_cnt    <= period;
            timeout_err <= 1'b0;
          end
        end
        WAIT: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bus.wr_idx <= '0;
          end else if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - PERIOD_W'(1);
          end else begin
            state         <= CONV;
            bus.adc_start <= 1'b1;
            to_cnt        <= '0;
          end
        end
        CONV: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bus.wr_idx <= '0;
          end else if (bus.adc_done) begin
            state          <= WRITE;
            bus.in_smpl    <= bus.adc_data;
            bus.enables    <= ONE << bus.wr_idx;
            bus.frame_done <= (bus.wr_idx == LAST);
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            bus.wr_idx  <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WRITE: begin
          tick_cnt <= period;
          if (bus.wr_idx == LAST) begin
            bus.wr_idx <= '0;
            if (continuous && !stop) begin
              state <= WAIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            bus.wr_idx <= '0;
          end else begin
            state      <= WAIT;
            bus.wr_idx <= bus.wr_idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: ADC responder predicts each bank write,
// a monitor pops and compares whenever an enable pulse appears.
module tb_sample_sequencer;
  localparam int DW = 12;
  localparam int N  = 14;
  localparam int IW = 4;
  localparam int PW = 16;
  localparam int TO = 8;

  typedef struct {
    int          cyc;
    int          idx;
    logic [DW-1:0] data;
    bit          fd;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [PW-1:0] period = '0;
  logic          busy;
  logic          timeout_err;

  sample_sequencer_if #(
    .DATA_WIDTH(DW), .N(N), .IDX_W(IW)
  ) bus ();

  sample_sequencer #(
    .DATA_WIDTH(DW), .N(N), .IDX_W(IW),
    .PERIOD_W(PW), .ADC_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .continuous(continuous),
    .period(period),
    .busy(busy),
    .timeout_err(timeout_err),
    .bus(bus)
  );

  int  chk = 0;
  int  errs = 0;
  int  cyc = 0;
  int  frames = 0;
  wr_t exp_q[$];

  int  clr_req = 0;
  int  arm_req = 0;
  int  arm_cyc = 0;
  int  spur_req = 0;
  int  lat_mode = 0;
  int  lat_fixed = 0;
  bit  data_mode = 0;

  int  pend = -1;
  logic [DW-1:0] pdata = '0;
  int  nxt = -2;
  int  m_idx = 0;
  int  to_cyc = -1;
  int  clr_seen = 0;
  int  arm_seen = 0;
  int  spur_seen = 0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // ADC model: answers each request after a chosen latency and
  // predicts the resulting write and the next request cycle.
  initial begin : responder
    int l;
    int wc;
    bit fd;
    logic [DW-1:0] d;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        m_idx = 0;
        nxt = -2;
        pend = -1;
        to_cyc = -1;
        exp_q.delete();
      end
      if (arm_req != arm_seen) begin
        arm_seen = arm_req;
        m_idx = 0;
        nxt = arm_cyc;
        pend = -1;
        to_cyc = -1;
      end
      bus.adc_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.adc_done = 1'b1;
          bus.adc_data = pdata;
          pend = -1;
        end
      end else if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        bus.adc_done = 1'b1;
        bus.adc_data = DW'($urandom);
      end
      if (!rst && bus.adc_start) begin
        check("adc_start_cyc", cyc, nxt);
        l = (lat_mode == 0) ? int'($urandom_range(0, 4))
                            : lat_fixed;
        d = data_mode ? DW'(32'h100 + m_idx) : DW'($urandom);
        if (l >= TO) begin
          to_cyc = cyc + TO;
          nxt = -2;
          m_idx = 0;
        end else begin
          wc = cyc + l + 1;
          fd = (m_idx == N - 1);
          exp_q.push_back('{wc, m_idx, d, fd});
          if (l == 0) begin
            bus.adc_done = 1'b1;
            bus.adc_data = d;
          end else begin
            pend = l;
            pdata = d;
          end
          m_idx = fd ? 0 : m_idx + 1;
          nxt = (fd && !continuous) ? -2 : wc + int'(period) + 2;
        end
      end
    end
  end

  // Monitor: every enable pulse must match the oldest prediction.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.enables != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", bus.enables, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_cyc", cyc, e.cyc);
            check("wr_en", bus.enables, longint'(1) << e.idx);
            check("wr_data", bus.in_smpl, e.data);
            check("wr_idx", bus.wr_idx, e.idx);
            check("wr_fd", bus.frame_done, e.fd);
          end
          if (bus.frame_done) frames++;
        end else if (bus.frame_done) begin
          check("stray_fd", bus.frame_done, 0);
        end
        if (cyc == to_cyc) begin
          check("to_err", timeout_err, 1);
          check("to_busy", busy, 0);
          check("to_idx", bus.wr_idx, 0);
        end
      end
    end
  end

  task automatic do_start(input int p, input bit c);
    @(negedge clk);
    period = PW'(p);
    continuous = c;
    start = 1'b1;
    arm_cyc = cyc + p + 2;
    arm_req++;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_to_clr", timeout_err, 0);
    check("start_idx", bus.wr_idx, 0);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < lim);
    check("idle_busy", busy, 0);
    check("idle_q", exp_q.size(), 0);
  endtask

  task automatic wait_en(input int b, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.enables[b] && n < lim);
    check("wait_en", bus.enables[b], 1);
  endtask

  function automatic longint outs();
    return longint'({busy, timeout_err, bus.adc_start,
                     bus.frame_done, bus.enables,
                     bus.in_smpl, bus.wr_idx});
  endfunction

  initial begin : main
    int f0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);

    lat_mode = 1;
    lat_fixed = 1;
    data_mode = 1;
    f0 = frames;
    do_start(3, 0);
    wait_idle(400);
    check("single_frames", frames - f0, 1);

    data_mode = 0;
    lat_fixed = 0;
    f0 = frames;
    do_start(0, 1);
    for (int n = 0; n < 300 && frames < f0 + 2; n++)
      @(negedge clk);
    @(negedge clk);
    continuous = 1'b0;
    wait_idle(300);
    check("cont_frames", frames - f0, 3);

    lat_fixed = 100;
    do_start(1, 0);
    wait_idle(100);
    check("timeout_sticky", timeout_err, 1);
    lat_fixed = TO - 1;
    do_start(1, 0);
    wait_idle(400);
    check("timeout_edge_ok", timeout_err, 0);

    lat_mode = 0;
    do_start(2, 0);
    wait_en(4, 200);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    clr_req++;
    check("stop_wait_busy", busy, 0);
    check("stop_wait_idx", bus.wr_idx, 0);
    repeat (15) @(negedge clk);

    do_start(2, 0);
    wait_en(3, 200);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    clr_req++;
    check("stop_wr_busy", busy, 0);
    check("stop_wr_idx", bus.wr_idx, 0);
    repeat (15) @(negedge clk);

    do_start(2, 0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_idle(400);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("start_stop_idle", busy, 0);

    lat_mode = 1;
    lat_fixed = 5;
    do_start(1, 1);
    for (int n = 0; n < 300 && m_idx != 7; n++)
      @(negedge clk);
    check("reach_idx6", m_idx, 7);
    #2;
    rst = 1'b1;
    clr_req++;
    #1;
    check("async_reset_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      spur_req++;
      repeat (3) @(negedge clk);
    end
    check("spur_busy", busy, 0);
    check("spur_outs", outs(), 0);

    lat_mode = 0;
    for (int k = 0; k < 3; k++) begin
      do_start(int'($urandom_range(0, 5)), 0);
      wait_idle(600);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             chk, errs);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
